// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default address width, depth helper and the
// default almost-full / almost-empty thresholds used by all FIFO controllers.
package fifo_pkg;

   localparam int FIFO_ADDRSIZE = 4;
   localparam int FIFO_AF_LEVEL = 12;
   localparam int FIFO_AE_LEVEL = 2;

   // Number of entries addressed by an ADDRSIZE-bit memory address.
   function automatic int fifo_depth(input int addrsize);
      return 1 << addrsize;
   endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between a FIFO user and sync_fifo_ctrl.
// master: drives push/pop/flush/clr_err; slave: drives addresses and flags.
interface sync_fifo_ctrl_if
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = FIFO_ADDRSIZE
) ();

   logic                push_i;
   logic                pop_i;
   logic                flush_i;
   logic                clr_err_i;
   logic [ADDRSIZE-1:0] waddr_o;
   logic [ADDRSIZE-1:0] raddr_o;
   logic                wclken_o;
   logic                wfull_o;
   logic                rempty_o;
   logic [ADDRSIZE:0]   count_o;
   logic                almost_full_o;
   logic                almost_empty_o;
   logic                overflow_o;
   logic                underflow_o;

   modport master (
      output push_i,
      output pop_i,
      output flush_i,
      output clr_err_i,
      input  waddr_o,
      input  raddr_o,
      input  wclken_o,
      input  wfull_o,
      input  rempty_o,
      input  count_o,
      input  almost_full_o,
      input  almost_empty_o,
      input  overflow_o,
      input  underflow_o
   );

   modport slave (
      input  push_i,
      input  pop_i,
      input  flush_i,
      input  clr_err_i,
      output waddr_o,
      output raddr_o,
      output wclken_o,
      output wfull_o,
      output rempty_o,
      output count_o,
      output almost_full_o,
      output almost_empty_o,
      output overflow_o,
      output underflow_o
   );

endinterface

// File: rtl/fifo_ptr.sv
// W-bit FIFO pointer counter: synchronous active-low reset, load, increment.
// Ports: clk_i, rst_ni, inc_i, load_i, load_val_i[W], ptr_o[W]. Load beats inc.
module fifo_ptr #(
   parameter int W = 5
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (load_i) begin
         ptr_q <= load_val_i;
      end else if (inc_i) begin
         ptr_q <= ptr_q + W'(1);
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller for a combinational-read memory.
// Ports: clk_i, rst_ni, bus (slave: push/pop/flush/clr_err in; addr/flags out).
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = FIFO_ADDRSIZE,
   parameter int AF_LEVEL = FIFO_AF_LEVEL,
   parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
   input logic              clk_i,
   input logic              rst_ni,
   sync_fifo_ctrl_if.slave  bus
);

   localparam int PW = ADDRSIZE + 1;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] count;
   logic          empty;
   logic          full;
   logic          push_acc;
   logic          pop_acc;
   logic          ovf_set;
   logic          udf_set;
   logic          ovf_q;
   logic          udf_q;

   // Extra MSB is the wrap bit: equal pointers mean empty, equal low bits
   // with differing wrap bits mean full.
   assign empty = (wptr == rptr);
   assign full  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                  (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
   assign count = wptr - rptr;

   // Qualified with rst_ni so a held push never strobes the memory
   // while the block is in reset.
   assign push_acc = bus.push_i & ~full & ~bus.flush_i & rst_ni;
   assign pop_acc  = bus.pop_i & ~empty & ~bus.flush_i & rst_ni;

   assign ovf_set = bus.push_i & full & ~bus.flush_i;
   assign udf_set = bus.pop_i & empty & ~bus.flush_i;

   fifo_ptr #(
      .W (PW)
   ) u_wptr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (push_acc),
      .load_i     (1'b0),
      .load_val_i ('0),
      .ptr_o      (wptr)
   );

   // Flush empties the FIFO by snapping the read pointer onto the
   // write pointer; contents are left in place but become unreachable.
   fifo_ptr #(
      .W (PW)
   ) u_rptr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (pop_acc),
      .load_i     (bus.flush_i),
      .load_val_i (wptr),
      .ptr_o      (rptr)
   );

   // Sticky errors; a set in the same cycle as a clear wins.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_err_i) begin
            ovf_q <= 1'b0;
         end
         if (udf_set) begin
            udf_q <= 1'b1;
         end else if (bus.clr_err_i) begin
            udf_q <= 1'b0;
         end
      end
   end

   assign bus.waddr_o        = wptr[ADDRSIZE-1:0];
   assign bus.raddr_o        = rptr[ADDRSIZE-1:0];
   assign bus.wclken_o       = push_acc;
   assign bus.wfull_o        = full;
   assign bus.rempty_o       = empty;
   assign bus.count_o        = count;
   assign bus.almost_full_o  = (count >= PW'(AF_LEVEL));
   assign bus.almost_empty_o = (count <= PW'(AE_LEVEL));
   assign bus.overflow_o     = ovf_q;
   assign bus.underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed steps plus random traffic,
// checked against a queue-based FIFO model and a bench-side data memory.
module tb_sync_fifo_ctrl;
   import fifo_pkg::*;

   localparam int AW = 4;
   localparam int D  = 16;
   localparam int AF = 12;
   localparam int AE = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sync_fifo_ctrl_if #(.ADDRSIZE(AW)) bus ();

   sync_fifo_ctrl #(
      .ADDRSIZE (AW),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue holds data in FIFO order, indices count
   // accepted pushes/pops since reset.
   int q[$];
   int wr_idx = 0;
   int rd_idx = 0;
   bit m_ovf = 0;
   bit m_udf = 0;
   int mem [D];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int n;
      n = q.size();
      chk("count", 32'(bus.count_o), n);
      chk("rempty", 32'(bus.rempty_o), 32'(n == 0));
      chk("wfull", 32'(bus.wfull_o), 32'(n == D));
      chk("almost_full", 32'(bus.almost_full_o), 32'(n >= AF));
      chk("almost_empty", 32'(bus.almost_empty_o), 32'(n <= AE));
      chk("waddr", 32'(bus.waddr_o), wr_idx % D);
      chk("raddr", 32'(bus.raddr_o), rd_idx % D);
      chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow_o), 32'(m_udf));
   endtask

   // One clock cycle: drive, check combinational strobes, clock, update
   // the model, check the registered state.
   task automatic cycle(bit push, bit pop, bit flush, bit clr);
      int n;
      int wdata;
      bit pa;
      bit pp;
      n = q.size();
      wdata = int'($urandom);
      bus.push_i    = push;
      bus.pop_i     = pop;
      bus.flush_i   = flush;
      bus.clr_err_i = clr;
      #1;
      pa = push && (n < D) && !flush;
      pp = pop && (n > 0) && !flush;
      chk("wclken", 32'(bus.wclken_o), 32'(pa));
      if (pp) chk("rdata", mem[bus.raddr_o], q[0]);
      if (bus.wclken_o === 1'b1) mem[bus.waddr_o] = wdata;
      @(posedge clk);
      if (push && n == D && !flush) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (pop && n == 0 && !flush) m_udf = 1;
      else if (clr) m_udf = 0;
      if (flush) begin
         q.delete();
         rd_idx = wr_idx;
      end else begin
         if (pp) begin
            void'(q.pop_front());
            rd_idx++;
         end
         if (pa) begin
            q.push_back(wdata);
            wr_idx++;
         end
      end
      #1;
      check_state();
   endtask

   task automatic do_reset(int cycles);
      rst_n = 1'b0;
      bus.push_i = 1'b1;
      bus.pop_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.clr_err_i = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         chk("wclken_in_reset", 32'(bus.wclken_o), 0);
      end
      q.delete();
      wr_idx = 0;
      rd_idx = 0;
      m_ovf = 0;
      m_udf = 0;
      bus.push_i = 1'b0;
      rst_n = 1'b1;
      #1;
      check_state();
   endtask

   initial begin
      int p;
      bit pu;
      bit po;
      bit fl;
      bit cl;

      // Reset with push held high.
      do_reset(3);

      // Fill to full, then one overflowing push.
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);

      // Simultaneous push+pop while full, then clear the error.
      cycle(1, 1, 0, 0);
      cycle(0, 0, 0, 1);

      // Drain to empty, then push+pop while empty.
      while (q.size() > 0) cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);

      // Build to 5 and stream push+pop for 40 cycles across wraps.
      while (q.size() < 5) cycle(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) cycle(1, 1, 0, 0);

      // Build to 9 and flush with a push pending; underflow stays set.
      while (q.size() < 9) cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 0);
      cycle(0, 0, 0, 1);

      // Error set and clear in the same cycle: set wins.
      cycle(0, 1, 0, 1);
      cycle(0, 0, 0, 1);

      // Random traffic with rare flush/clear.
      for (int i = 0; i < 600; i++) begin
         p  = int'($urandom_range(0, 99));
         pu = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
         po = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
         fl = (p < 3);
         cl = (p > 94);
         cycle(pu, po, fl, cl);
      end

      // Reset mid-operation with data held.
      while (q.size() < 7) cycle(1, 0, 0, 0);
      do_reset(1);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
